sync_updown_counter: RTL and testbench
======================================

SYNC_UPDOWN_COUNTER -- requirements
Module: sync_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning counter bit width (legal 2..16).
REQ-002 SHALL have port clk  input  1  clock; all state updates on the negative edge of clk.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled at the negative edge of clk.
REQ-004 SHALL have port op  input  2  operation: 00 hold, 01 count, 10 load, 11 clear.
REQ-005 SHALL have port up  input  1  count direction: 1 increment, 0 decrement; used only when op=01.
REQ-006 SHALL have port din  input  WIDTH  parallel load value; used only when op=10.
REQ-007 SHALL have port q  output  WIDTH  registered count value.
REQ-008 SHALL have port q_  output  WIDTH  bitwise complement of q, always equal to ~q.
REQ-009 SHALL have port tc  output  1  combinational terminal count: 1 when (up=1 and q=all-ones) or (up=0 and q=0).
REQ-010 SHALL have port wrap  output  1  registered one-cycle pulse, 1 in the cycle after a count operation crossed terminal count.

Function
REQ-011 SHALL update q only at the negative edge of clk; there SHALL be no combinational path from inputs to q.
REQ-012 SHALL apply op=00 (hold): q unchanged; wrap=0.
REQ-013 SHALL apply op=01 with up=1: q <= q+1 modulo 2^WIDTH.
REQ-014 SHALL apply op=01 with up=0: q <= q-1 modulo 2^WIDTH.
REQ-015 SHALL apply op=10 (load): q <= din in one edge; wrap=0.
REQ-016 SHALL apply op=11 (clear): q <= 0; wrap=0.
REQ-017 SHALL drive each bit i with JK semantics: count uses J=K=(toggle condition of bit i); load uses J=din[i], K=~din[i]; clear uses J=0, K=1; hold uses J=K=0.
REQ-018 SHALL compute the toggle condition of bit i as the AND of q[0..i-1] when counting up and of q_[0..i-1] when counting down; bit 0 always toggles.
REQ-019 SHALL set wrap=1 for exactly one cycle after an op=01 edge taken while tc=1; otherwise wrap=0.
REQ-020 SHALL evaluate tc from the current up input even when op is not 01.
REQ-021 SHALL sample a change in direction (up) at the same edge as the count: a sequence up, down returns q to its prior value.

Reset
REQ-022 SHALL, when reset=1 at a negative edge of clk, force q=0, q_=all-ones and wrap=0, overriding every op.
REQ-023 SHALL, when reset is asserted mid-count, discard the pending operation; the first edge after deassertion SHALL apply op to q=0.
REQ-024 SHALL have q=0 and wrap=0 from simulation start, before the first clock edge.

Configuration
REQ-025 SHALL use macro SYNC_UPDOWN_COUNTER_SATURATE_EN.
REQ-026 SHALL, when the macro is defined, make an op=01 edge with tc=1 hold q (saturate at all-ones up or 0 down) and still pulse wrap for one cycle.
REQ-027 SHALL, when the macro is undefined, wrap modulo 2^WIDTH per REQ-013/REQ-014.

Structure
REQ-028 SHALL place the op encodings (OP_HOLD, OP_COUNT, OP_LOAD, OP_CLEAR) in the shared lab package as named constants.
REQ-029 SHALL build each state bit from one sub-module, jk_cell: a negative-edge JK flip-flop with reset implemented around a single D storage element (D = J&~Q | ~K&Q); WIDTH instances.
REQ-030 SHALL contain no storage other than the jk_cell instances and the wrap register.

Verification
REQ-031 SHALL test reset: op=01, up=1 for 5 edges, then reset=1 for 1 edge -> q=0, q_=all-ones, wrap=0; next op=01 edge -> q=1.
REQ-032 SHALL test up-wrap (WIDTH=8): load 8'hFE, then op=01, up=1 for 2 edges -> q=FF then 00; tc=1 while q=FF; wrap=1 only in the cycle after the 00 edge.
REQ-033 SHALL test down-wrap: clear, then op=01, up=0 for 1 edge -> q=FF, wrap pulses once; with SATURATE_EN defined -> q stays 00, wrap still pulses.
REQ-034 SHALL test load/hold: din=8'h5A, op=10 -> q=5A; op=00 for 3 edges -> q=5A, wrap=0.
REQ-035 SHALL test direction reversal: load 8'h10, op=01 up=1 for 3 edges, then up=0 for 3 edges -> q=13 then 10.
REQ-036 SHALL test clear versus reset priority: op=11 with reset=1 and q=37 -> q=0 and wrap=0; op=11 alone from q=37 -> q=0.

Source files
------------

// File: rtl/sync_updown_counter_pkg.sv
// sync_updown_counter_pkg
//   Shared constants for the up/down counter slice.
//   OP_* : two-bit operation encodings on the counter's op port.
package sync_updown_counter_pkg;

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_COUNT = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

endpackage

// File: rtl/sync_updown_counter_jk_cell.sv
// jk_cell
//   One counter state bit: negative-edge JK flip-flop with synchronous,
//   active-high reset, built around a single D storage element.
//   Ports:
//     clk   : clock, state changes on the falling edge
//     reset : synchronous active-high reset, forces q=0
//     j, k  : JK controls (00 hold, 10 set, 01 clear, 11 toggle)
//     q     : stored bit
module jk_cell (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  // Power-up value keeps the count at 0 before the first edge.
  logic q_r = 1'b0;

  always_ff @(negedge clk) begin
    if (reset) q_r <= 1'b0;
    else       q_r <= (j & ~q_r) | (~k & q_r);
  end

  assign q = q_r;

endmodule

// File: rtl/sync_updown_counter.sv
// sync_updown_counter
//   WIDTH-bit synchronous up/down counter with hold/count/load/clear,
//   built from WIDTH jk_cell bits. All state updates on the falling edge.
//   Optional feature macro: SYNC_UPDOWN_COUNTER_SATURATE_EN
//     defined   : a count at terminal count holds q (saturates), wrap still pulses
//     undefined : counting wraps modulo 2^WIDTH
//   Ports:
//     clk   : clock (negative-edge active)
//     reset : synchronous active-high reset, overrides every op
//     op    : 00 hold, 01 count, 10 load, 11 clear
//     up    : count direction, 1 up / 0 down
//     din   : parallel load value
//     q     : registered count
//     q_    : ~q
//     tc    : combinational terminal count for the current direction
//     wrap  : one-cycle pulse after a count taken at terminal count
module sync_updown_counter
  import sync_updown_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic             up,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_,
  output logic             tc,
  output logic             wrap
);

  logic [WIDTH-1:0] tog_up, tog_dn, tog;
  logic [WIDTH-1:0] j, k;
  logic             count_en, sat_hold;
  logic             wrap_r = 1'b0;

  assign q_       = ~q;
  assign count_en = (op == OP_COUNT);
  assign tc       = up ? (&q) : ~(|q);

`ifdef SYNC_UPDOWN_COUNTER_SATURATE_EN
  // At the end of the range a count freezes the bits instead of rolling over.
  assign sat_hold = count_en & tc;
`else
  assign sat_hold = 1'b0;
`endif

  // Ripple toggle chain: bit i toggles when all lower bits are 1 (up)
  // or all lower bits are 0, i.e. q_ all 1 (down). Bit 0 always toggles.
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_tog
      if (i == 0) begin : g_lsb
        assign tog_up[i] = 1'b1;
        assign tog_dn[i] = 1'b1;
      end else begin : g_upper
        assign tog_up[i] = tog_up[i-1] & q[i-1];
        assign tog_dn[i] = tog_dn[i-1] & q_[i-1];
      end
    end
  endgenerate

  assign tog = up ? tog_up : tog_dn;

  // JK drive per op; default is hold (J=K=0).
  always_comb begin
    j = '0;
    k = '0;
    case (op)
      OP_COUNT: begin
        if (!sat_hold) begin
          j = tog;
          k = tog;
        end
      end
      OP_LOAD: begin
        j = din;
        k = ~din;
      end
      OP_CLEAR: begin
        k = '1;
      end
      default: ;
    endcase
  end

  jk_cell u_bit [WIDTH-1:0] (
    .clk   (clk),
    .reset (reset),
    .j     (j),
    .k     (k),
    .q     (q)
  );

  // wrap marks that the previous edge was a count taken at terminal count.
  always_ff @(negedge clk) begin
    if (reset) wrap_r <= 1'b0;
    else       wrap_r <= count_en & tc;
  end

  assign wrap = wrap_r;

endmodule

// File: tb/tb_sync_updown_counter.sv
module tb_sync_updown_counter;

  localparam int WIDTH = 8;
  localparam int MAXV  = (1 << WIDTH) - 1;

`ifdef SYNC_UPDOWN_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b1;
  logic             reset = 1'b0;
  logic [1:0]       op = 2'b00;
  logic             up = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] q, q_;
  logic             tc, wrap;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_q    = 0;
  bit m_wrap = 0;

  sync_updown_counter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .up    (up),
    .din   (din),
    .q     (q),
    .q_    (q_),
    .tc    (tc),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  function automatic bit model_tc(input int qv, input bit dir);
    return (dir && qv == MAXV) || (!dir && qv == 0);
  endfunction

  // Drive one operation, advance the model by one falling edge.
  task automatic apply(input bit rst, input logic [1:0] o, input bit u, input int d);
    bit t;
    reset = rst; op = o; up = u; din = d[WIDTH-1:0];
    t = model_tc(m_q, u);
    @(negedge clk);
    #1;
    if (rst) begin
      m_q = 0; m_wrap = 0;
    end else begin
      m_wrap = 0;
      case (o)
        2'd1: begin
          m_wrap = t;
          if (!(SAT && t)) m_q = u ? (m_q + 1) % (MAXV + 1) : (m_q + MAXV) % (MAXV + 1);
        end
        2'd2: m_q = d & MAXV;
        2'd3: m_q = 0;
        default: ;
      endcase
    end
    reset = 0; op = 2'd0;
  endtask

  task automatic test_reset;
    n_checks++;
    if (q !== 8'h00 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL power_on: q=%h wrap=%b want q=00 wrap=0", q, wrap);
    end
    for (int i = 0; i < 5; i++) apply(0, 2'd1, 1, 0);
    n_checks++;
    if (q !== 8'h05) begin n_fail++; $display("FAIL reset_precount: q=%h want 05", q); end
    apply(1, 2'd1, 1, 0);
    n_checks++;
    if (q !== 8'h00 || q_ !== 8'hFF || wrap !== 1'b0) begin
      n_fail++; $display("FAIL reset_apply: q=%h q_=%h wrap=%b want 00 FF 0", q, q_, wrap);
    end
    apply(0, 2'd1, 1, 0);
    n_checks++;
    if (q !== 8'h01) begin n_fail++; $display("FAIL reset_first_count: q=%h want 01", q); end
  endtask

  task automatic test_up_wrap;
    logic [7:0] exp_q;
    apply(0, 2'd2, 0, 8'hFE);
    apply(0, 2'd1, 1, 0);
    n_checks++;
    if (q !== 8'hFF || wrap !== 1'b0) begin
      n_fail++; $display("FAIL upwrap_ff: q=%h wrap=%b want FF 0", q, wrap);
    end
    up = 1; op = 2'd1; #1;
    n_checks++;
    if (tc !== 1'b1) begin n_fail++; $display("FAIL upwrap_tc: tc=%b want 1", tc); end
    apply(0, 2'd1, 1, 0);
    exp_q = SAT ? 8'hFF : 8'h00;
    n_checks++;
    if (q !== exp_q || wrap !== 1'b1) begin
      n_fail++; $display("FAIL upwrap_roll: q=%h wrap=%b want %h 1", q, wrap, exp_q);
    end
    apply(0, 2'd0, 1, 0);
    n_checks++;
    if (wrap !== 1'b0 || q !== exp_q) begin
      n_fail++; $display("FAIL upwrap_pulse_end: q=%h wrap=%b want %h 0", q, wrap, exp_q);
    end
  endtask

  task automatic test_down_wrap;
    logic [7:0] exp_q;
    apply(0, 2'd3, 0, 0);
    up = 0; #1;
    n_checks++;
    if (tc !== 1'b1) begin n_fail++; $display("FAIL downwrap_tc: tc=%b want 1", tc); end
    // tc follows up even while op is hold
    up = 1; #1;
    n_checks++;
    if (tc !== 1'b0) begin n_fail++; $display("FAIL downwrap_tc_dir: tc=%b want 0", tc); end
    apply(0, 2'd1, 0, 0);
    exp_q = SAT ? 8'h00 : 8'hFF;
    n_checks++;
    if (q !== exp_q || wrap !== 1'b1) begin
      n_fail++; $display("FAIL downwrap: q=%h wrap=%b want %h 1", q, wrap, exp_q);
    end
    apply(0, 2'd0, 0, 0);
    n_checks++;
    if (wrap !== 1'b0) begin n_fail++; $display("FAIL downwrap_once: wrap=%b want 0", wrap); end
  endtask

  task automatic test_load_hold;
    apply(0, 2'd2, 0, 8'h5A);
    n_checks++;
    if (q !== 8'h5A || q_ !== 8'hA5) begin
      n_fail++; $display("FAIL load: q=%h q_=%h want 5A A5", q, q_);
    end
    for (int i = 0; i < 3; i++) apply(0, 2'd0, i[0], 8'hC3);
    n_checks++;
    if (q !== 8'h5A || wrap !== 1'b0) begin
      n_fail++; $display("FAIL hold: q=%h wrap=%b want 5A 0", q, wrap);
    end
  endtask

  task automatic test_reversal;
    apply(0, 2'd2, 0, 8'h10);
    for (int i = 0; i < 3; i++) apply(0, 2'd1, 1, 0);
    n_checks++;
    if (q !== 8'h13) begin n_fail++; $display("FAIL reverse_up: q=%h want 13", q); end
    for (int i = 0; i < 3; i++) apply(0, 2'd1, 0, 0);
    n_checks++;
    if (q !== 8'h10) begin n_fail++; $display("FAIL reverse_down: q=%h want 10", q); end
  endtask

  task automatic test_clear_vs_reset;
    apply(0, 2'd2, 0, 8'h37);
    apply(1, 2'd3, 0, 0);
    n_checks++;
    if (q !== 8'h00 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL clear_with_reset: q=%h wrap=%b want 00 0", q, wrap);
    end
    apply(0, 2'd2, 0, 8'h37);
    apply(0, 2'd3, 1, 0);
    n_checks++;
    if (q !== 8'h00 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL clear_alone: q=%h wrap=%b want 00 0", q, wrap);
    end
  endtask

  task automatic test_random;
    int errs = 0;
    bit r, u;
    logic [1:0] o;
    int d;
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 15) == 0);
      // bias toward counting so wraps actually happen
      o = ($urandom_range(0, 3) != 0) ? 2'd1 : 2'($urandom_range(0, 3));
      u = $urandom_range(0, 1);
      d = $urandom_range(0, MAXV);
      if (n % 50 == 0) d = (n % 100 == 0) ? MAXV - 1 : 1;
      reset = r; op = o; up = u; din = d[WIDTH-1:0];
      #1;
      n_checks++;
      if (tc !== model_tc(m_q, u)) begin
        n_fail++; errs++;
        if (errs < 10) $display("FAIL rand_tc[%0d]: tc=%b want %b", n, tc, model_tc(m_q, u));
      end
      apply(r, o, u, d);
      n_checks++;
      if (q !== m_q[WIDTH-1:0] || q_ !== ~m_q[WIDTH-1:0] || wrap !== m_wrap) begin
        n_fail++; errs++;
        if (errs < 10)
          $display("FAIL rand_state[%0d]: q=%h q_=%h wrap=%b want %h %h %b",
                   n, q, q_, wrap, m_q[WIDTH-1:0], ~m_q[WIDTH-1:0], m_wrap);
      end
    end
  endtask

  initial begin
    #1;
    test_reset;
    test_up_wrap;
    test_down_wrap;
    test_load_hold;
    test_reversal;
    test_clear_vs_reset;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
